// File: rtl/game_flow_ctrl.sv
// Turn-based game flow controller: menu, play, pause and settle phases with player rotation.
// Optional turn timer (prescaler, per-turn countdown, forfeit) is built when TURN_TIMER_EN is defined.
module game_flow_ctrl #(
    parameter int unsigned NUM_PLAYERS = 2,
    parameter int unsigned TURN_TICKS  = 30,
    parameter int unsigned TICK_DIV    = 100000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       is_pressed,
    input  logic       pause_req,
    input  logic       move_done,
    input  logic       game_over,
    input  logic [2:0] game_over_player,
    output logic [1:0] state,
    output logic [2:0] cur_player,
    output logic [7:0] time_left,
    output logic [2:0] winner,
    output logic       timeout,
    output logic       sound_req
);

    if (NUM_PLAYERS < 2 || NUM_PLAYERS > 8 || TURN_TICKS < 1 || TURN_TICKS > 255 ||
        TICK_DIV < 2) begin : g_param_check
        $error("game_flow_ctrl: parameter out of range");
    end

    typedef enum logic [1:0] {
        StMenu   = 2'd0,
        StPlay   = 2'd1,
        StPause  = 2'd2,
        StSettle = 2'd3
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] cur_player_q, cur_player_d;
    logic [2:0] winner_q, winner_d;
    logic       sound_req_q, sound_req_d;
    logic [2:0] next_player;
    logic       play_start;
    logic       play_active;
    logic       end_game;
    logic       turn_move;
    logic       forfeit;

    // Events resolved in priority order: game_over > pause_req > move_done > timer.
    assign play_start  = (state_q == StMenu) && is_pressed;
    assign end_game    = (state_q == StPlay) && game_over;
    assign play_active = (state_q == StPlay) && !game_over && !pause_req;
    assign turn_move   = play_active && move_done;
    assign next_player = (cur_player_q == 3'(NUM_PLAYERS - 1)) ? 3'd0 : cur_player_q + 3'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StMenu;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StMenu:   if (is_pressed) state_d = StPlay;
            StPlay: begin
                if (game_over) begin
                    state_d = StSettle;
                end else if (pause_req) begin
                    state_d = StPause;
                end
            end
            StPause:  if (pause_req) state_d = StPlay;
            StSettle: if (is_pressed) state_d = StMenu;
            default:  state_d = StMenu;
        endcase
    end

`ifdef TURN_TIMER_EN
    localparam int unsigned PW = $clog2(TICK_DIV);

    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    time_left_q, time_left_d;
    logic          timeout_q, timeout_d;
    logic          tick;

    // A move in the same cycle as the wrap takes precedence and restarts the turn.
    assign tick    = play_active && !move_done && (presc_q == PW'(TICK_DIV - 1));
    assign forfeit = tick && (time_left_q <= 8'd1);

    always_comb begin
        presc_d     = presc_q;
        time_left_d = time_left_q;
        timeout_d   = 1'b0;
        if (play_start || turn_move) begin
            presc_d     = '0;
            time_left_d = 8'(TURN_TICKS);
        end else if (play_active) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            if (forfeit) begin
                time_left_d = 8'(TURN_TICKS);
                timeout_d   = 1'b1;
            end else if (tick) begin
                time_left_d = time_left_q - 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q     <= '0;
            time_left_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            time_left_q <= time_left_d;
            timeout_q   <= timeout_d;
        end
    end

    assign time_left = time_left_q;
    assign timeout   = timeout_q;
`else
    assign forfeit   = 1'b0;
    assign time_left = '0;
    assign timeout   = 1'b0;
`endif

    always_comb begin
        cur_player_d = cur_player_q;
        winner_d     = winner_q;
        sound_req_d  = 1'b0;
        if (play_start) begin
            cur_player_d = '0;
            winner_d     = '0;
        end else if (end_game) begin
            winner_d    = game_over_player;
            sound_req_d = 1'b1;
        end else if (turn_move || forfeit) begin
            cur_player_d = next_player;
            sound_req_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_player_q <= '0;
            winner_q     <= '0;
            sound_req_q  <= 1'b0;
        end else begin
            cur_player_q <= cur_player_d;
            winner_q     <= winner_d;
            sound_req_q  <= sound_req_d;
        end
    end

    assign state      = state_q;
    assign cur_player = cur_player_q;
    assign winner     = winner_q;
    assign sound_req  = sound_req_q;

endmodule

// File: doc/game_flow_ctrl.md
GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 SHALL have parameter NUM_PLAYERS, default 2: players in rotation, range 2..8.
REQ-002 SHALL have parameter TURN_TICKS, default 30: turn time budget in ticks, range 1..255.
REQ-003 SHALL have parameter TICK_DIV, default 100000000: clk cycles per tick, at least 2.
REQ-004 SHALL have port clk  in  1  system clock; all state updates on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port is_pressed  in  1  one-cycle confirm-key pulse.
REQ-007 SHALL have port pause_req  in  1  one-cycle pause/resume toggle pulse.
REQ-008 SHALL have port move_done  in  1  one-cycle legal-move-completed pulse.
REQ-009 SHALL have port game_over  in  1  one-cycle end-of-game pulse.
REQ-010 SHALL have port game_over_player  in  3  winning player index, sampled with game_over.
REQ-011 SHALL have port state  out  2  MENU=0, PLAY=1, PAUSE=2, SETTLE=3.
REQ-012 SHALL have port cur_player  out  3  player index to move.
REQ-013 SHALL have port time_left  out  8  ticks remaining in current turn.
REQ-014 SHALL have port winner  out  3  winner index, valid in SETTLE.
REQ-015 SHALL have port timeout  out  1  one-cycle pulse on turn forfeit.
REQ-016 SHALL have port sound_req  out  1  one-cycle pulse per turn change or game end.

Function
REQ-017 All outputs SHALL be registered; a qualifying input in cycle N is visible on outputs in cycle N+1.
REQ-018 MENU: is_pressed -> PLAY; cur_player<=0, time_left<=TURN_TICKS, prescaler<=0, winner<=0.
REQ-019 PLAY priority, highest first: game_over > pause_req > move_done > timer expiry; lower-priority events in the same cycle are dropped.
REQ-020 PLAY + game_over -> SETTLE; winner<=game_over_player; sound_req pulses.
REQ-021 PLAY + pause_req -> PAUSE; prescaler and time_left hold their values.
REQ-022 PLAY + move_done: cur_player<=(cur_player+1) mod NUM_PLAYERS, wrapping NUM_PLAYERS-1 -> 0; time_left<=TURN_TICKS; prescaler<=0; sound_req pulses.
REQ-023 Prescaler SHALL count 0..TICK_DIV-1 in PLAY only; a tick occurs when it wraps TICK_DIV-1 -> 0.
REQ-024 On a tick with time_left>1: time_left decrements by 1.
REQ-025 On a tick with time_left==1: timeout and sound_req pulse; player advances and time_left reloads exactly as in REQ-022.
REQ-026 PAUSE: pause_req -> PLAY, resuming the same count; is_pressed, move_done and game_over SHALL be ignored.
REQ-027 SETTLE: is_pressed -> MENU; cur_player, winner and time_left hold until MENU exit.
REQ-028 is_pressed SHALL be ignored in PLAY.
REQ-029 game_over_player >= NUM_PLAYERS SHALL be stored unchanged.
REQ-030 timeout and sound_req SHALL never assert for more than one consecutive cycle from a single event.

Reset
REQ-031 rst high SHALL immediately force state=MENU, cur_player=0, time_left=0, winner=0, timeout=0, sound_req=0, prescaler=0, in any state and at any point in a turn.
REQ-032 First transition SHALL be possible on the first rising clk edge after rst deasserts.

Configuration
REQ-033 Macro TURN_TIMER_EN defined: prescaler, tick countdown and forfeit per REQ-023..REQ-025 are present.
REQ-034 Macro TURN_TIMER_EN undefined: no prescaler logic; time_left constant 0; timeout constant 0; turns change only on move_done.

Verification (NUM_PLAYERS=3, TURN_TICKS=4, TICK_DIV=5, TURN_TIMER_EN defined unless stated)
REQ-035 rst, then is_pressed -> state=1, cur_player=0, time_left=4 one cycle later.
REQ-036 Three move_done pulses in PLAY -> cur_player 1, 2, 0; three single-cycle sound_req pulses; time_left=4 after each.
REQ-037 Idle 20 cycles in PLAY -> time_left 3, 2, 1 at cycles 5, 10, 15; at cycle 20 timeout pulses, cur_player=1, time_left=4.
REQ-038 pause_req at cycle 7 of a turn, wait 50 cycles, pause_req -> time_left stays 3 during PAUSE; next decrement 3 cycles after resume.
REQ-039 game_over with move_done and pause_req in the same cycle, game_over_player=2 -> state=3, winner=2, cur_player unchanged; then is_pressed -> state=0.
REQ-040 TURN_TIMER_EN undefined, idle 100 cycles in PLAY -> time_left=0, timeout never asserted, cur_player unchanged.
